fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage with IF/ID pipeline register for the RV32I SoC core. Owns the PC and issues instruction-memory requests. Handles stalls, branch/jump redirects and memory wait states. Presents the fetched word, its PC and a flush flag to the decode stage; when flush is set, decode substitutes a NOP (addi x0,x0,0 = 32'h00000013).

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
NOP_INSTR, 32'h00000013, word driven on instr_out whenever the IF/ID entry is invalid.

Ports:
clk_in  input  1  core clock, rising edge.
rst_in  input  1  reset, asynchronous, active-low.
stall_in  input  1  hazard stall; hold PC and IF/ID contents.
branch_taken_in  input  1  redirect request from execute (branch taken or jal/jalr).
branch_target_in  input  32  redirect target address.
imem_req_out  output  1  fetch request valid.
imem_addr_out  output  32  fetch address (word aligned).
imem_ready_in  input  1  imem_data_in valid for the current request this cycle.
imem_data_in  input  32  fetched instruction word.
instr_out  output  32  IF/ID instruction.
pc_out  output  32  IF/ID PC.
pc_plus4_out  output  32  pc_out + 4, used as the jal/jalr link value.
flush_out  output  1  IF/ID entry invalid; decode treats it as a NOP.

Behaviour:
- Reset (rst_in=0, async): pc=RESET_PC, state=BOOT, instr_out=NOP_INSTR, pc_out=RESET_PC, pc_plus4_out=RESET_PC+4, flush_out=1, imem_req_out=0.
- imem_addr_out = {pc[31:2],2'b00}, combinational from the PC register.
- imem_req_out = 1 in RUN and WAIT; 0 in BOOT and SQUASH.
- FSM states: BOOT, RUN, WAIT, SQUASH.
  - BOOT: one cycle after reset deassertion, no request; then -> RUN.
  - RUN and WAIT, imem_ready_in=1 and stall_in=0 (accept):
    - IF/ID <= {imem_data_in, pc}, flush_out <= 0
    - pc <= pc+4 (32-bit wrap: 32'hFFFFFFFC -> 0)
    - next state RUN.
  - RUN, imem_ready_in=0 and stall_in=0: IF/ID gets a bubble (flush_out <= 1, instr_out <= NOP_INSTR, pc_out <= pc); PC held; next state WAIT.
  - WAIT: same rules as RUN; stays in WAIT until accept.
  - stall_in=1, no branch (RUN or WAIT): PC, IF/ID and state all held. The memory response that cycle is discarded and re-requested at the same address.
  - SQUASH: entered for one cycle after a redirect. No request; IF/ID gets a bubble; then -> RUN.
- branch_taken_in=1 (any state except BOOT):
  - pc <= {branch_target_in[31:2],2'b00}
  - IF/ID <= bubble (flush_out=1)
  - next state SQUASH.
  - Overrides stall_in and imem_ready_in; the word returned that cycle is dropped.
- branch_taken_in during BOOT: ignored.
- pc_plus4_out is always registered together with pc_out (pc_out+4, wrapping).
- Fetch-to-IF/ID latency: 1 cycle from accept.
- Back-to-back throughput: one instruction per cycle with imem_ready_in held high.
- Redirect penalty: exactly two bubble cycles (the redirect cycle and the SQUASH cycle) before the target instruction appears with flush_out=0.
- Reset asserted mid-operation returns all state to reset values immediately, including any in-flight WAIT.

Test Plan:
- Reset then run, imem_ready_in=1, memory returns addr>>2 → cycle after BOOT: imem_addr_out=0,4,8; instr_out=0,1,2 on successive cycles; flush_out goes 0 one cycle after the first accept.
- stall_in=1 for 3 cycles at pc=8 → imem_addr_out stays 8; instr_out/pc_out frozen at pc_out=4; after release, pc_out=8 next cycle.
- imem_ready_in=0 for 2 cycles at pc=12 → flush_out=1 and instr_out=32'h00000013 for 2 cycles, PC stays 12; on ready, pc_out=12, flush_out=0.
- branch_taken_in=1 with target 32'h00000103 while stall_in=1 → pc becomes 32'h00000100; flush_out=1 for 2 cycles; then pc_out=32'h100, pc_plus4_out=32'h104.
- RESET_PC=32'hFFFFFFF8, ready held high → addresses FFFFFFF8, FFFFFFFC, 00000000; pc_plus4_out of FFFFFFFC equals 0.
- rst_in pulled low asynchronously mid-WAIT → outputs return to reset values before the next clock edge; a branch during the following BOOT cycle is ignored.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of the RV32I core, including the IF/ID pipeline
// register. It owns the PC, issues instruction-memory requests, and handles
// hazard stalls, execute-stage redirects and memory wait states.
//
// Ports:
//   clk_in            core clock, rising edge
//   rst_in            asynchronous active-low reset
//   stall_in          hazard stall: hold the PC, IF/ID and the FSM state
//   branch_taken_in   redirect request from execute (taken branch, jal, jalr)
//   branch_target_in  redirect target; the low two bits are cleared
//   imem_req_out      fetch request valid (RUN and WAIT only)
//   imem_addr_out     word-aligned fetch address taken from the PC register
//   imem_ready_in     imem_data_in is valid for the current request
//   imem_data_in      fetched instruction word
//   instr_out         IF/ID instruction (NOP_INSTR while the entry is invalid)
//   pc_out            IF/ID PC
//   pc_plus4_out      pc_out + 4 (link value), registered alongside pc_out
//   flush_out         IF/ID entry invalid; decode treats it as a NOP
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        stall_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_target_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ready_in,
    input  logic [31:0] imem_data_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out,
    output logic        flush_out
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_WAIT   = 2'd2,
        ST_SQUASH = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic        req_r;
    logic [31:0] instr_r;
    logic [31:0] pc_out_r;
    logic [31:0] pc_plus4_r;
    logic        flush_r;

    // Clears the byte-offset bits so every fetch address is word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // Fetch FSM: PC, request flag and IF/ID register all move together here.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r    <= ST_BOOT;
            pc_r       <= RESET_PC;
            req_r      <= 1'b0;
            instr_r    <= NOP_INSTR;
            pc_out_r   <= RESET_PC;
            pc_plus4_r <= RESET_PC + 32'd4;
            flush_r    <= 1'b1;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    // One quiet cycle after reset; redirects are ignored here.
                    state_r <= ST_RUN;
                    req_r   <= 1'b1;
                end
                ST_RUN, ST_WAIT: begin
                    if (branch_taken_in) begin
                        // Redirect wins over stall and ready; the returned word is dropped.
                        pc_r       <= word_align(branch_target_in);
                        instr_r    <= NOP_INSTR;
                        pc_out_r   <= pc_r;
                        pc_plus4_r <= pc_r + 32'd4;
                        flush_r    <= 1'b1;
                        req_r      <= 1'b0;
                        state_r    <= ST_SQUASH;
                    end else if (stall_in) begin
                        // Everything holds; the same address is re-requested next cycle.
                        state_r <= state_r;
                        req_r   <= 1'b1;
                    end else if (imem_ready_in) begin
                        instr_r    <= imem_data_in;
                        pc_out_r   <= pc_r;
                        pc_plus4_r <= pc_r + 32'd4;
                        flush_r    <= 1'b0;
                        pc_r       <= pc_r + 32'd4;
                        req_r      <= 1'b1;
                        state_r    <= ST_RUN;
                    end else begin
                        // Memory not ready: bubble into IF/ID, keep asking.
                        instr_r    <= NOP_INSTR;
                        pc_out_r   <= pc_r;
                        pc_plus4_r <= pc_r + 32'd4;
                        flush_r    <= 1'b1;
                        req_r      <= 1'b1;
                        state_r    <= ST_WAIT;
                    end
                end
                ST_SQUASH: begin
                    if (branch_taken_in) begin
                        pc_r       <= word_align(branch_target_in);
                        instr_r    <= NOP_INSTR;
                        pc_out_r   <= pc_r;
                        pc_plus4_r <= pc_r + 32'd4;
                        flush_r    <= 1'b1;
                        req_r      <= 1'b0;
                        state_r    <= ST_SQUASH;
                    end else begin
                        // Second redirect bubble; fetching resumes at the target.
                        instr_r    <= NOP_INSTR;
                        pc_out_r   <= pc_r;
                        pc_plus4_r <= pc_r + 32'd4;
                        flush_r    <= 1'b1;
                        req_r      <= 1'b1;
                        state_r    <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_BOOT;
                    req_r   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_out  = req_r;
    assign imem_addr_out = word_align(pc_r);
    assign instr_out     = instr_r;
    assign pc_out        = pc_out_r;
    assign pc_plus4_out  = pc_plus4_r;
    assign flush_out     = flush_r;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [31:0] tgt = 32'd0;
    logic        ready = 1'b0;
    logic        req;
    logic [31:0] addr, data, instr, pc, pc4;
    logic        flush;

    logic        req2, flush2;
    logic [31:0] addr2, data2, instr2, pc2, pc42;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Instruction memory: word at address a is a >> 2.
    assign data  = addr >> 2;
    assign data2 = addr2 >> 2;

    fetch_stage dut (
        .clk_in(clk), .rst_in(rst_n), .stall_in(stall),
        .branch_taken_in(br), .branch_target_in(tgt),
        .imem_req_out(req), .imem_addr_out(addr),
        .imem_ready_in(ready), .imem_data_in(data),
        .instr_out(instr), .pc_out(pc), .pc_plus4_out(pc4), .flush_out(flush)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk_in(clk), .rst_in(rst_n), .stall_in(1'b0),
        .branch_taken_in(1'b0), .branch_target_in(32'd0),
        .imem_req_out(req2), .imem_addr_out(addr2),
        .imem_ready_in(1'b1), .imem_data_in(data2),
        .instr_out(instr2), .pc_out(pc2), .pc_plus4_out(pc42), .flush_out(flush2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [31:0] m_pc, m_instr, m_pcout;
    bit          m_flush, m_boot, m_squash, m_pcv;

    task automatic m_reset(input logic [31:0] rpc);
        m_pc = rpc; m_instr = NOP; m_pcout = rpc;
        m_flush = 1'b1; m_boot = 1'b1; m_squash = 1'b0; m_pcv = 1'b1;
    endtask

    task automatic m_step(input bit s, input bit r, input bit b, input logic [31:0] t);
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (b) begin
            m_pc = {t[31:2], 2'b00};
            m_instr = NOP; m_flush = 1'b1; m_pcv = 1'b0; m_squash = 1'b1;
        end else if (m_squash) begin
            m_squash = 1'b0;
            m_instr = NOP; m_flush = 1'b1; m_pcv = 1'b0;
        end else if (s) begin
            // hold everything
        end else if (r) begin
            m_instr = m_pc >> 2; m_pcout = m_pc; m_pcv = 1'b1; m_flush = 1'b0;
            m_pc = m_pc + 32'd4;
        end else begin
            m_instr = NOP; m_flush = 1'b1; m_pcout = m_pc; m_pcv = 1'b1;
        end
    endtask

    task automatic m_check(input string tag);
        chk({tag, "_req"}, {31'd0, req}, {31'd0, !m_boot && !m_squash});
        chk({tag, "_addr"}, addr, m_pc);
        chk({tag, "_instr"}, instr, m_instr);
        chk({tag, "_flush"}, {31'd0, flush}, {31'd0, m_flush});
        if (m_pcv) begin
            chk({tag, "_pc"}, pc, m_pcout);
            chk({tag, "_pc4"}, pc4, m_pcout + 32'd4);
        end
    endtask

    // One clock cycle: inputs driven now (after a negedge), checked #1 after posedge.
    task automatic cyc(input bit s, input bit r, input bit b, input logic [31:0] t, input string tag);
        stall = s; ready = r; br = b; tgt = t;
        @(posedge clk);
        m_step(s, r, b, t);
        #1;
        m_check(tag);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall = 1'b0; br = 1'b0; ready = 1'b0; tgt = 32'd0;
        m_reset(32'd0);
        repeat (2) @(negedge clk);
        m_check("rst");
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        s, r, b;
        logic [31:0] t;
        logic        rq;
        logic [31:0] a, i;
        logic        f, pv;
        logic [31:0] p;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic r, input logic b, input logic [31:0] t,
                                input logic rq, input logic [31:0] a, input logic [31:0] i,
                                input logic f, input logic pv, input logic [31:0] p);
        vec_t v;
        v.s = s; v.r = r; v.b = b; v.t = t; v.rq = rq; v.a = a; v.i = i;
        v.f = f; v.pv = pv; v.p = p;
        return v;
    endfunction

    vec_t        tv[13];
    logic [31:0] w_addr[4];
    logic [31:0] w_pc[4];

    initial begin
        tv[0]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   NOP,      1'b1, 1'b1, 32'h0);
        tv[1]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   32'h0,    1'b0, 1'b1, 32'h0);
        tv[2]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   32'h1,    1'b0, 1'b1, 32'h4);
        tv[3]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   32'h1,    1'b0, 1'b1, 32'h4);
        tv[4]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   32'h1,    1'b0, 1'b1, 32'h4);
        tv[5]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   32'h1,    1'b0, 1'b1, 32'h4);
        tv[6]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'hC,   32'h2,    1'b0, 1'b1, 32'h8);
        tv[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   NOP,      1'b1, 1'b1, 32'hC);
        tv[8]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   NOP,      1'b1, 1'b1, 32'hC);
        tv[9]  = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  32'h3,    1'b0, 1'b1, 32'hC);
        tv[10] = mk(1'b1, 1'b1, 1'b1, 32'h103, 1'b0, 32'h100, NOP,      1'b1, 1'b0, 32'h0);
        tv[11] = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h100, NOP,      1'b1, 1'b0, 32'h0);
        tv[12] = mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 32'h40,   1'b0, 1'b1, 32'h100);
        // Wrap-around instance: address after each of the first four cycles, and the IF/ID PC.
        w_addr[0] = 32'hFFFF_FFF8; w_addr[1] = 32'hFFFF_FFFC; w_addr[2] = 32'h0; w_addr[3] = 32'h4;
        w_pc[0]   = 32'hFFFF_FFF8; w_pc[1]   = 32'hFFFF_FFF8; w_pc[2]   = 32'hFFFF_FFFC; w_pc[3] = 32'h0;

        @(negedge clk);
        do_reset();
        chk("wrap_rst_pc", pc2, 32'hFFFF_FFF8);
        chk("wrap_rst_pc4", pc42, 32'hFFFF_FFFC);

        for (int k = 0; k < 13; k++) begin
            stall = tv[k].s; ready = tv[k].r; br = tv[k].b; tgt = tv[k].t;
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_req", k), {31'd0, req}, {31'd0, tv[k].rq});
            chk($sformatf("tbl%0d_addr", k), addr, tv[k].a);
            chk($sformatf("tbl%0d_instr", k), instr, tv[k].i);
            chk($sformatf("tbl%0d_flush", k), {31'd0, flush}, {31'd0, tv[k].f});
            if (tv[k].pv) begin
                chk($sformatf("tbl%0d_pc", k), pc, tv[k].p);
                chk($sformatf("tbl%0d_pc4", k), pc4, tv[k].p + 32'd4);
            end
            if (k < 4) begin
                chk($sformatf("wrap%0d_addr", k), addr2, w_addr[k]);
                if (k > 0) begin
                    chk($sformatf("wrap%0d_pc", k), pc2, w_pc[k]);
                    chk($sformatf("wrap%0d_pc4", k), pc42, w_pc[k] + 32'd4);
                    chk($sformatf("wrap%0d_instr", k), instr2, w_pc[k] >> 2);
                    chk($sformatf("wrap%0d_flush", k), {31'd0, flush2}, 32'd0);
                end
            end
            @(negedge clk);
        end

        // ---------------- randomized run against the model ----------------
        do_reset();
        for (int n = 0; n < 600; n++) begin
            cyc(($urandom_range(4) == 0), ($urandom_range(3) != 0),
                ($urandom_range(9) == 0), $urandom, "rnd");
        end

        // ---------------- async reset in WAIT, then branch during BOOT ----------------
        do_reset();
        cyc(1'b0, 1'b1, 1'b0, 32'h0, "pre");
        cyc(1'b0, 1'b1, 1'b0, 32'h0, "pre");
        cyc(1'b0, 1'b1, 1'b0, 32'h0, "pre");
        stall = 1'b0; ready = 1'b0; br = 1'b0;
        @(posedge clk);
        #1;
        chk("wait_flush", {31'd0, flush}, 32'd1);
        chk("wait_addr", addr, 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_instr", instr, NOP);
        chk("arst_flush", {31'd0, flush}, 32'd1);
        chk("arst_req", {31'd0, req}, 32'd0);
        chk("arst_addr", addr, 32'h0);
        chk("arst_pc", pc, 32'h0);
        chk("arst_pc4", pc4, 32'h4);
        @(negedge clk);
        rst_n = 1'b1; br = 1'b1; tgt = 32'h0000_0200; ready = 1'b1;
        @(posedge clk);
        #1;
        chk("boot_br_addr", addr, 32'h0);
        chk("boot_br_req", {31'd0, req}, 32'd1);
        chk("boot_br_flush", {31'd0, flush}, 32'd1);
        @(negedge clk);
        br = 1'b0;
        @(posedge clk);
        #1;
        chk("post_boot_instr", instr, 32'h0);
        chk("post_boot_pc", pc, 32'h0);
        chk("post_boot_flush", {31'd0, flush}, 32'd0);
        chk("post_boot_addr", addr, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
